sbq_sensor_conditioner: RTL

- Front-end stage for the bank-queue people counter.
- Takes the raw, asynchronous, active-low entry-gate and exit-gate photo-sensors and synchronises and debounces them.
- Produces clean active-low levels for the edge-driven queue counter, plus registered single-cycle arrival/departure pulses for clocked consumers.
- Simultaneous entry/exit edges are serialised so no event is lost.

---
 rtl/sbq_sensor_conditioner.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sbq_sensor_conditioner.sv
// sbq_sensor_conditioner
// Front end of the bank-queue people counter. It brings the raw active-low
// entry and exit photo-sensors into the clock domain, debounces them and
// exposes clean active-low levels. It also produces single-cycle
// arrival/departure pulses. When entry and exit are accepted in the same
// cycle, the departure is held back one cycle so that no event is lost.
module sbq_sensor_conditioner #(
   parameter int DB_CNT = 4,   // consecutive samples needed to accept a level (2..15)
   parameter int CNT_W  = 4,   // debounce counter width, 2**CNT_W > DB_CNT
   parameter int GL_W   = 8    // saturating glitch counter width
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_sens_front,
   input  logic            i_sens_back,
   output logic            o_clean_front,
   output logic            o_clean_back,
   output logic            o_arrive_pulse,
   output logic            o_depart_pulse,
   output logic [GL_W-1:0] o_glitch_count
);

   // Last counter value before a new level is accepted.
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_CNT - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ZERO = {CNT_W{1'b0}};
   // Saturation ceiling, kept one bit wider so a +2 step cannot wrap.
   localparam logic [GL_W:0]    LP_GL_MAX   = {1'b0, {GL_W{1'b1}}};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic             r_sync1_f;
   logic             r_sync2_f;
   logic             r_sync1_b;
   logic             r_sync2_b;
   logic [CNT_W-1:0] r_cnt_f;
   logic [CNT_W-1:0] r_cnt_b;
   logic             r_clean_f;
   logic             r_clean_b;
   logic             r_clean_dly_f;
   logic             r_clean_dly_b;
   logic             r_pending;
   logic             r_arrive;
   logic             r_depart;
   logic [GL_W-1:0]  r_glitch;

   // ------------------------------------------------------------------
   // Next-state wires
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] w_cnt_f_nxt;
   logic [CNT_W-1:0] w_cnt_b_nxt;
   logic             w_clean_f_nxt;
   logic             w_clean_b_nxt;
   logic             w_glitch_f;
   logic             w_glitch_b;
   logic [1:0]       w_glitch_inc;
   logic [GL_W:0]    w_glitch_sum;
   logic [GL_W-1:0]  w_glitch_nxt;
   logic             w_fe_f;
   logic             w_fe_b;
   logic             w_arrive_nxt;
   logic             w_depart_nxt;
   logic             w_pending_nxt;

   // Two-flop synchronisers; idle (released) level is 1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1_f <= 1'b1;
         r_sync2_f <= 1'b1;
         r_sync1_b <= 1'b1;
         r_sync2_b <= 1'b1;
      end else begin
         r_sync1_f <= i_sens_front;
         r_sync2_f <= r_sync1_f;
         r_sync1_b <= i_sens_back;
         r_sync2_b <= r_sync1_b;
      end
   end

   // Entry-channel debounce: count mismatching samples, accept on the last one.
   always_comb begin
      w_cnt_f_nxt   = r_cnt_f;
      w_clean_f_nxt = r_clean_f;
      if (r_sync2_f == r_clean_f) begin
         w_cnt_f_nxt = LP_CNT_ZERO;
      end else if (r_cnt_f == LP_CNT_LAST) begin
         w_cnt_f_nxt   = LP_CNT_ZERO;
         w_clean_f_nxt = r_sync2_f;
      end else begin
         w_cnt_f_nxt = r_cnt_f + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Exit-channel debounce: same qualification rule as the entry channel.
   always_comb begin
      w_cnt_b_nxt   = r_cnt_b;
      w_clean_b_nxt = r_clean_b;
      if (r_sync2_b == r_clean_b) begin
         w_cnt_b_nxt = LP_CNT_ZERO;
      end else if (r_cnt_b == LP_CNT_LAST) begin
         w_cnt_b_nxt   = LP_CNT_ZERO;
         w_clean_b_nxt = r_sync2_b;
      end else begin
         w_cnt_b_nxt = r_cnt_b + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Debounce counters and accepted clean levels.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt_f   <= LP_CNT_ZERO;
         r_cnt_b   <= LP_CNT_ZERO;
         r_clean_f <= 1'b1;
         r_clean_b <= 1'b1;
      end else begin
         r_cnt_f   <= w_cnt_f_nxt;
         r_cnt_b   <= w_cnt_b_nxt;
         r_clean_f <= w_clean_f_nxt;
         r_clean_b <= w_clean_b_nxt;
      end
   end

   // A bounce is a sample that returns to the clean level mid-qualification.
   always_comb begin
      w_glitch_f   = (r_sync2_f == r_clean_f) && (r_cnt_f != LP_CNT_ZERO);
      w_glitch_b   = (r_sync2_b == r_clean_b) && (r_cnt_b != LP_CNT_ZERO);
      w_glitch_inc = {1'b0, w_glitch_f} + {1'b0, w_glitch_b};
      w_glitch_sum = {1'b0, r_glitch} + {{(GL_W-1){1'b0}}, w_glitch_inc};
      if (w_glitch_sum > LP_GL_MAX) begin
         w_glitch_nxt = LP_GL_MAX[GL_W-1:0];
      end else begin
         w_glitch_nxt = w_glitch_sum[GL_W-1:0];
      end
   end

   // Saturating glitch counter shared by both channels.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_glitch <= {GL_W{1'b0}};
      end else begin
         r_glitch <= w_glitch_nxt;
      end
   end

   // Delayed copies of the clean levels for falling-edge detection.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clean_dly_f <= 1'b1;
         r_clean_dly_b <= 1'b1;
      end else begin
         r_clean_dly_f <= r_clean_f;
         r_clean_dly_b <= r_clean_b;
      end
   end

   // Arbitration: arrivals take priority, and a colliding departure waits in
   // the pending bit. A fresh exit edge that coincides with draining the
   // pending departure is re-parked rather than dropped.
   always_comb begin
      w_fe_f        = r_clean_dly_f & ~r_clean_f;
      w_fe_b        = r_clean_dly_b & ~r_clean_b;
      w_arrive_nxt  = 1'b0;
      w_depart_nxt  = 1'b0;
      w_pending_nxt = r_pending;
      if (w_fe_f) begin
         w_arrive_nxt  = 1'b1;
         w_pending_nxt = r_pending | w_fe_b;
      end else if (r_pending) begin
         w_depart_nxt  = 1'b1;
         w_pending_nxt = w_fe_b;
      end else if (w_fe_b) begin
         w_depart_nxt  = 1'b1;
         w_pending_nxt = 1'b0;
      end else begin
         w_pending_nxt = 1'b0;
      end
   end

   // Registered event pulses and the deferred-departure flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_arrive  <= 1'b0;
         r_depart  <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_arrive  <= w_arrive_nxt;
         r_depart  <= w_depart_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   assign o_clean_front  = r_clean_f;
   assign o_clean_back   = r_clean_b;
   assign o_arrive_pulse = r_arrive;
   assign o_depart_pulse = r_depart;
   assign o_glitch_count = r_glitch;

endmodule
